// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file with two prioritised write ports,
// optional hardwired-zero R0, optional write-to-read bypass and a sequenced bulk-clear engine.
module register_file_mp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we0,
    input  logic [AW-1:0]           waddr0,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic                    we1,
    input  logic [AW-1:0]           waddr1,
    input  logic [WIDTH-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    input  logic                    clear_req,
    output logic                    busy,
    output logic                    wr_conflict
);
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    ptr, ptr_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             eff0, eff1, last;

    // In range and not the hardwired-zero register; applies to both reads and writes.
    function automatic logic valid(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign eff0 = we0 && valid(waddr0) && state == IDLE;
    assign eff1 = we1 && valid(waddr1) && state == IDLE;
    assign last = ptr == AW'(DEPTH - 1);
    assign busy = state == SWEEP;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            ptr_nx   = '0;
            state_nx = clear_req ? SWEEP : IDLE;
        end else begin
            ptr_nx   = last ? '0 : ptr + AW'(1);
            state_nx = last ? IDLE : SWEEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            wr_conflict <= eff0 && eff1 && waddr0 == waddr1;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == SWEEP) begin
            mem[ptr] <= '0;
        end else begin
            if (eff0) mem[waddr0] <= wdata0;
            if (eff1) mem[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[k*AW +: AW];
        assign rdata[k*WIDTH +: WIDTH] =
            !valid(ra)                             ? '0     :
            (BYPASS != 0 && eff1 && waddr1 == ra) ? wdata1 :
            (BYPASS != 0 && eff0 && waddr0 == ra) ? wdata0 : mem[ra];
    end
endmodule
